// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage definitions: default address map, NOP encoding, queue entry type.
package mips_defs;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT  = 32'h0000_6FFC;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;

  // Misaligned or outside the instruction window.
  function automatic logic fetch_adel(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > limit);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side signals of the fetch queue; the queue binds the slave modport.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_i;
  logic [31:0]   instr_i;
  logic          fetch_valid;
  logic          flush;
  logic          deq;
  logic          stall_o;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc8;
  logic          if_adel;
  logic [CW-1:0] count;

  modport master (
    output pc_i, instr_i, fetch_valid, flush, deq,
    input  stall_o, if_valid, if_pc, if_instr, if_pc8, if_adel, count
  );

  modport slave (
    input  pc_i, instr_i, fetch_valid, flush, deq,
    output stall_o, if_valid, if_pc, if_instr, if_pc8, if_adel, count
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one write port, one asynchronous read port, no data reset.
module fetch_queue_mem
  import mips_defs::fetch_entry_t;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_entry_t             rdata
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch queue between PC/IMEM and decode; stalls the PC when full, drops all on flush.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import mips_defs::fetch_entry_t;
  import mips_defs::fetch_adel;
  import mips_defs::NOP_INSTR;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = mips_defs::RESET_PC,
  parameter logic [31:0] IM_BASE  = mips_defs::IM_BASE,
  parameter logic [31:0] IM_LIMIT = mips_defs::IM_LIMIT
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] valid_q;
  logic             full, empty;
  logic             enq_fire, deq_fire, we;
  fetch_entry_t     wdata, head;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign enq_fire = bus.fetch_valid && !full && !bus.flush;
  assign deq_fire = bus.deq && !empty && !bus.flush;

  always_comb begin
    wdata.pc    = bus.pc_i;
    wdata.adel  = fetch_adel(bus.pc_i, IM_BASE, IM_LIMIT);
    wdata.instr = wdata.adel ? NOP_INSTR : bus.instr_i;
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp, byp_take;
  assign byp      = empty && enq_fire;
  // A bypassed fetch consumed by decode the same cycle never touches storage.
  assign byp_take = byp && bus.deq;
  assign we       = enq_fire && !byp_take;
`else
  assign we       = enq_fire;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (we) begin
        wr_ptr          <= wr_ptr + AW'(1);
        valid_q[wr_ptr] <= 1'b1;
      end
      if (deq_fire) begin
        rd_ptr          <= rd_ptr + AW'(1);
        valid_q[rd_ptr] <= 1'b0;
      end
      count_q <= count_q + CW'(we) - CW'(deq_fire);
    end
  end

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_comb begin
    bus.if_valid = 1'b0;
    bus.if_pc    = RESET_PC;
    bus.if_instr = NOP_INSTR;
    bus.if_adel  = 1'b0;
    if (valid_q[rd_ptr]) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = head.pc;
      bus.if_instr = head.instr;
      bus.if_adel  = head.adel;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (byp) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = wdata.pc;
      bus.if_instr = wdata.instr;
      bus.if_adel  = wdata.adel;
    end
`endif
    bus.if_pc8 = bus.if_pc + 32'd8;
  end

  assign bus.stall_o = full;
  assign bus.count   = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes expected entries, a negedge monitor checks/pops.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] E_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] E_BASE     = 32'h0000_3000;
  localparam logic [31:0] E_LIMIT    = 32'h0000_6FFC;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus();

  fetch_queue #(
    .DEPTH(DEPTH), .RESET_PC(E_RESET_PC), .IM_BASE(E_BASE), .IM_LIMIT(E_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  int          occ = 0;
  bit          byp_flag = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  function automatic exp_t make_exp(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.adel  = (pc % 4 != 0) || (pc < E_BASE) || (pc > E_LIMIT);
    e.instr = e.adel ? 32'h0 : instr;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy/stall every cycle, head entry against scoreboard front, pop on accepted deq.
  always @(negedge clk) begin
    bit exp_valid;
    exp_t h;
    exp_valid = (occ != 0) || byp_flag;
    check("count", 32'(bus.count), occ);
    check("stall_o", 32'(bus.stall_o), 32'(occ == DEPTH));
    check("if_valid", 32'(bus.if_valid), 32'(exp_valid));
    if (exp_valid && bus.if_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_empty: got valid head expected queued entry at %0t", $time);
      end else begin
        h = exp_q[0];
        check("if_pc", bus.if_pc, h.pc);
        check("if_instr", bus.if_instr, h.instr);
        check("if_adel", 32'(bus.if_adel), 32'(h.adel));
        check("if_pc8", bus.if_pc8, h.pc + 32'd8);
        if (bus.deq && !bus.flush) void'(exp_q.pop_front());
      end
    end else if (!exp_valid) begin
      check("empty_pc", bus.if_pc, E_RESET_PC);
      check("empty_pc8", bus.if_pc8, E_RESET_PC + 32'd8);
      check("empty_instr", bus.if_instr, 32'h0);
      check("empty_adel", 32'(bus.if_adel), 32'h0);
    end
  end

  // Called at posedge+1; drives one cycle of inputs and updates the reference after the edge.
  task automatic cycle(input bit fv, input logic [31:0] pc, input logic [31:0] instr,
                       input bit dq, input bit fl);
    bit enq, dok;
    bus.fetch_valid = fv;
    bus.pc_i        = pc;
    bus.instr_i     = instr;
    bus.deq         = dq;
    bus.flush       = fl;
    byp_flag        = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (occ == 0 && fv && !fl) begin
      byp_flag = 1'b1;
      exp_q.push_back(make_exp(pc, instr));
    end
`endif
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      occ = 0;
    end else if (byp_flag) begin
      if (!dq) occ++;
    end else begin
      enq = fv && (occ < DEPTH);
      dok = dq && (occ > 0);
      if (enq) exp_q.push_back(make_exp(pc, instr));
      occ = occ + int'(enq) - int'(dok);
    end
    byp_flag = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic async_reset_mid();
    bus.fetch_valid = 1'b0;
    bus.deq         = 1'b0;
    bus.flush       = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_if_valid", 32'(bus.if_valid), 32'h0);
    check("arst_count", 32'(bus.count), 32'h0);
    exp_q.delete();
    occ = 0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    int r;
    bus.fetch_valid = 1'b0;
    bus.pc_i        = 32'h0;
    bus.instr_i     = 32'h0;
    bus.deq         = 1'b0;
    bus.flush       = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    idle(3);

    // Fill, then a fifth fetch while stalled is dropped.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h3000 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    check("fill_count", 32'(bus.count), 32'd4);
    check("fill_stall", 32'(bus.stall_o), 32'h1);
    cycle(1'b1, 32'h3010, $urandom, 1'b0, 1'b0);
    check("stalled_head", bus.if_pc, 32'h3000);

    // Simultaneous enqueue/dequeue at three entries.
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h3010, $urandom, 1'b1, 1'b0);
    check("simul_count", 32'(bus.count), 32'd3);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("simul_head", bus.if_pc, 32'h3010);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with concurrent fetch and deq.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3014 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h3020, $urandom, 1'b1, 1'b1);
    check("flush_count", 32'(bus.count), 32'h0);
    check("flush_valid", 32'(bus.if_valid), 32'h0);
    check("flush_stall", 32'(bus.stall_o), 32'h0);
    idle(1);

    // Address errors and the top legal address.
    cycle(1'b1, 32'h3002, 32'h8C01_0000, 1'b0, 1'b0);
    check("adel_misalign", 32'(bus.if_adel), 32'h1);
    check("adel_nop", bus.if_instr, 32'h0);
    cycle(1'b1, 32'h2FFC, 32'h1234_5678, 1'b1, 1'b0);
    check("adel_below", 32'(bus.if_adel), 32'h1);
    cycle(1'b1, 32'h6FFC, 32'h2402_0001, 1'b1, 1'b0);
    check("limit_ok_adel", 32'(bus.if_adel), 32'h0);
    check("limit_ok_instr", bus.if_instr, 32'h2402_0001);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset with two entries queued.
    cycle(1'b1, 32'h3030, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h3034, $urandom, 1'b0, 1'b0);
    async_reset_mid();
    idle(1);

`ifdef FETCH_QUEUE_BYPASS_EN
    cycle(1'b1, 32'h3040, $urandom, 1'b1, 1'b0);
    check("bypass_count", 32'(bus.count), 32'h0);
`endif

    // Randomized traffic against the reference queue.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       pc = 32'h3000 + 32'(4 * $urandom_range(0, 32'hFFF));
      else if (r == 7) pc = (32'h3000 + 32'($urandom_range(0, 32'h3FFF))) | 32'h1;
      else if (r == 8) pc = 32'($urandom_range(0, 32'h2FFF)) & ~32'h3;
      else             pc = 32'h7000 + 32'(4 * $urandom_range(0, 32'hFF));
      cycle($urandom_range(0, 3) != 0, pc, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
